// File: rtl/split_check_if.sv
// Candidate, split-walk and result signals between the solver front end
// and the split check sequencer.
interface split_check_if #(
    parameter int IDX_W = 3,
    parameter int ID_W  = 8
);
    logic             cand_valid;
    logic             cand_ready;
    logic [ID_W-1:0]  cand_id;
    logic             hold;
    logic             abort;
    logic [IDX_W-1:0] split_sel;
    logic             split_x;
    logic             res_valid;
    logic             res_ready;
    logic             res_pass;
    logic [IDX_W-1:0] res_fail_idx;
    logic [ID_W-1:0]  res_id;
    logic [15:0]      stat_checked;
    logic [15:0]      stat_passed;

    modport master (
        output cand_valid, cand_id, abort, split_x, res_ready,
        input  cand_ready, hold, split_sel, res_valid, res_pass,
        input  res_fail_idx, res_id, stat_checked, stat_passed
    );

    modport slave (
        input  cand_valid, cand_id, abort, split_x, res_ready,
        output cand_ready, hold, split_sel, res_valid, res_pass,
        output res_fail_idx, res_id, stat_checked, stat_passed
    );
endinterface

// File: rtl/split_check_sched.sv
// Walks the split checker outputs one per cycle, stops on the first false
// split and reports pass/fail with the failing index.
module split_check_sched #(
    parameter int NUM_SPLITS = 8,
    parameter int IDX_W      = 3,
    parameter int ID_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    split_check_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPLITS - 1);

    state_t           state;
    logic [IDX_W-1:0] sel_q;
    logic             pass_q;
    logic [IDX_W-1:0] fail_idx_q;
    logic [ID_W-1:0]  id_q;
    logic [15:0]      stat_checked_q;
    logic [15:0]      stat_passed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel_q          <= '0;
            pass_q         <= 1'b0;
            fail_idx_q     <= '0;
            id_q           <= '0;
            stat_checked_q <= '0;
            stat_passed_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cand_valid) begin
                        id_q  <= bus.cand_id;
                        sel_q <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    // abort wins over a false split in the same cycle
                    priority case (1'b1)
                        bus.abort: begin
                            sel_q <= '0;
                            state <= IDLE;
                        end
                        !bus.split_x: begin
                            pass_q     <= 1'b0;
                            fail_idx_q <= sel_q;
                            state      <= DONE;
                        end
                        (sel_q == LAST): begin
                            pass_q     <= 1'b1;
                            fail_idx_q <= '0;
                            state      <= DONE;
                        end
                        default: sel_q <= sel_q + 1'b1;
                    endcase
                end
                DONE: begin
                    if (bus.res_ready) begin
                        sel_q <= '0;
                        state <= IDLE;
                        if (stat_checked_q != 16'hFFFF)
                            stat_checked_q <= stat_checked_q + 16'd1;
                        if (pass_q && stat_passed_q != 16'hFFFF)
                            stat_passed_q <= stat_passed_q + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cand_ready   = (state == IDLE);
    assign bus.hold         = (state == EVAL);
    assign bus.res_valid    = (state == DONE);
    assign bus.split_sel    = sel_q;
    assign bus.res_pass     = pass_q;
    assign bus.res_fail_idx = fail_idx_q;
    assign bus.res_id       = id_q;
    assign bus.stat_checked = stat_checked_q;
    assign bus.stat_passed  = stat_passed_q;
endmodule
